// File: rtl/pwm_pkg.sv
// pwm_pkg: FSM encoding and default timing constants shared by the PWM generator and capture blocks.
package pwm_pkg;
   typedef enum logic {ST_IDLE, ST_MEAS} state_t;
   localparam int PWM_N = 32;
   localparam logic [31:0] PWM_PERIOD = 32'd85899;
   localparam logic [31:0] PWM_TIMEOUT = 2 * PWM_PERIOD;
endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: 2-flop synchronizer, optional 3-sample glitch filter (PWM_CAPTURE_FILT_EN), edge detector.
module pwm_in_sync (
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);
   logic s1, s2, prev;
   always_ff @(posedge clk or posedge rst)
      if (rst) {s1, s2, prev} <= '0;
      else {s1, s2, prev} <= {pwm_in, s1, level};
`ifdef PWM_CAPTURE_FILT_EN
   logic h1, h2, filt;
   always_ff @(posedge clk or posedge rst)
      if (rst) {h1, h2, filt} <= '0;
      else {h1, h2, filt} <= {s2, h1, level};
   // level follows only when three consecutive samples agree, otherwise holds
   assign level = (s2 & h1 & h2) | (filt & (s2 | h1 | h2));
`else
   assign level = s2;
`endif
   assign rise = level & ~prev;
   assign fall = ~level & prev;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM line in clk cycles, with stall detection.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILT_EN.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int N = PWM_N,
   parameter logic [N-1:0] TIMEOUT = N'(PWM_TIMEOUT)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         pwm_in,
   output logic [N-1:0] period,
   output logic [N-1:0] duty,
   output logic         valid,
   output logic         stalled,
   output logic         stall_level
);
   localparam logic [N-1:0] ONE = N'(1);
   logic level, rise, fall, hi, hflag_q;
   state_t state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, period_d, duty_d;
   logic valid_d, stalled_d, stall_level_d;

   pwm_in_sync u_sync (.clk(clk), .rst(rst), .pwm_in(pwm_in), .level(level), .rise(rise), .fall(fall));

   // high-phase tracker; equals level throughout a measurement since MEAS always starts on a rise
   assign hi = rise | (hflag_q & ~fall);

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      hcnt_d = hcnt_q;
      period_d = period;
      duty_d = duty;
      valid_d = 1'b0;
      stalled_d = stalled;
      stall_level_d = stall_level;
      if (!en) begin
         state_d = ST_IDLE;
         cnt_d = '0;
         hcnt_d = '0;
      end else if (state_q == ST_IDLE) begin
         state_d = rise ? ST_MEAS : ST_IDLE;
         cnt_d = rise ? ONE : '0;
         hcnt_d = rise ? ONE : '0;
         stalled_d = rise ? 1'b0 : stalled;
      end else if (rise) begin
         period_d = cnt_q;
         duty_d = hcnt_q;
         valid_d = 1'b1;
         cnt_d = ONE;
         hcnt_d = ONE;
         stalled_d = 1'b0;
      end else if (cnt_q == TIMEOUT) begin
         state_d = ST_IDLE;
         cnt_d = '0;
         hcnt_d = '0;
         period_d = '0;
         duty_d = '0;
         stalled_d = 1'b1;
         stall_level_d = level;
      end else begin
         cnt_d = cnt_q + ONE;
         hcnt_d = (hi && hcnt_q != TIMEOUT) ? hcnt_q + ONE : hcnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         hcnt_q <= '0;
         hflag_q <= 1'b0;
         period <= '0;
         duty <= '0;
         valid <= 1'b0;
         stalled <= 1'b0;
         stall_level <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         hcnt_q <= hcnt_d;
         hflag_q <= hi;
         period <= period_d;
         duty <= duty_d;
         valid <= valid_d;
         stalled <= stalled_d;
         stall_level <= stall_level_d;
      end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus with an expected-measurement queue checked on every valid strobe.
module tb_pwm_capture;
`ifdef PWM_CAPTURE_FILT_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif
   localparam int TO = 200;

   typedef struct {int p; int d; int due;} exp_t;

   logic clk = 1'b0, rst, en, pwm_in;
   logic [31:0] period, duty;
   logic valid, stalled, stall_level;
   int tests = 0, fails = 0, cyc = 0, last_h = -1, last_l = 0;
   exp_t q[$];
   exp_t e;

   pwm_capture #(.N(32), .TIMEOUT(32'd200)) dut (
      .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in), .period(period), .duty(duty),
      .valid(valid), .stalled(stalled), .stall_level(stall_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string tag, longint obs, longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk)
      if (valid) begin
         if (q.size() == 0) check("unexpected_valid", 1, 0);
         else begin
            e = q.pop_front();
            check("period", period, e.p);
            check("duty", duty, e.d);
            check("latency", cyc, e.due);
         end
      end

   task automatic start_rise(int h, int l);
      if (last_h >= 0) q.push_back('{last_h + last_l, last_h, cyc + LAT});
      last_h = h;
      last_l = l;
      pwm_in = 1'b1;
   endtask

   task automatic wave(int h, int l);
      start_rise(h, l);
      repeat (h) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (l) @(posedge clk);
      #1;
   endtask

   task automatic glitch_wave();
`ifdef PWM_CAPTURE_FILT_EN
      start_rise(30, 70);
      repeat (10) @(posedge clk);
      #1 pwm_in = 1'b0;
      @(posedge clk);
      #1 pwm_in = 1'b1;
      repeat (19) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (10) @(posedge clk);
      #1 pwm_in = 1'b1;
      @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (20) @(posedge clk);
      #1 pwm_in = 1'b1;
      repeat (2) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (37) @(posedge clk);
      #1;
`else
      wave(10, 1);
      wave(19, 10);
      wave(1, 20);
      wave(2, 37);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      en = 1'b0;
      pwm_in = 1'b0;
      #2;
      check("rst_period", period, 0);
      check("rst_duty", duty, 0);
      check("rst_valid", valid, 0);
      check("rst_stalled", stalled, 0);
      check("rst_stall_level", stall_level, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      // steady 30/70 then duty step to 80
      repeat (5) wave(30, 70);
      repeat (2) wave(80, 20);
      wave(30, 70);
      // period exactly TIMEOUT: the edge wins over the stall
      wave(50, 150);
      wave(30, 70);
      check("edge_wins_stalled", stalled, 0);
      // stall with line held high
      start_rise(300, 50);
      repeat (LAT + TO - 1) @(posedge clk);
      #1 check("stall_early", stalled, 0);
      @(posedge clk);
      #1 check("stall_set", stalled, 1);
      check("stall_level", stall_level, 1);
      check("stall_period", period, 0);
      check("stall_duty", duty, 0);
      repeat (300 - LAT - TO) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (50) @(posedge clk);
      #1 check("stall_holds", stalled, 1);
      last_h = -1;
      wave(30, 70);
      check("stall_cleared", stalled, 0);
      wave(30, 70);
      // enable dropped mid high phase
      start_rise(30, 70);
      last_h = -1;
      repeat (10) @(posedge clk);
      #1 en = 1'b0;
      repeat (20) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (30) @(posedge clk);
      #1 en = 1'b1;
      check("en_hold_period", period, 100);
      check("en_hold_duty", duty, 30);
      check("en_hold_stalled", stalled, 0);
      repeat (40) @(posedge clk);
      #1;
      repeat (3) wave(30, 70);
      // async reset while a valid is due
      last_h = -1;
      start_rise(30, 70);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check("arst_period", period, 0);
      check("arst_duty", duty, 0);
      check("arst_valid", valid, 0);
      pwm_in = 1'b0;
      last_h = -1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      repeat (3) wave(30, 70);
      // glitches injected into the 30/70 waveform
      repeat (2) glitch_wave();
      wave(30, 70);
      check("pending", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures period and high time of one incoming PWM-style signal, in clk cycles. Typical sources are a servo/ESC command line or a looped-back motor drive pin.
- It is the receive-side counterpart of the car's PWM generators. It lets firmware or a closed-loop block confirm the frequency and duty actually present on a wheel drive line.
- Publishes a fresh period/duty pair once per completed PWM cycle, with a one-cycle valid strobe, and flags a stalled line.

Parameters:
- N, 32, width of the period/duty counters and outputs.
- TIMEOUT, 32'd171798, cycles without a rising edge before the line is declared stalled (2 ms at 85.9 MHz). Must be in 2..2^N-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  capture enable; 0 forces the IDLE state
- pwm_in  input  1  asynchronous PWM input
- period  output  N  last measured period, in clk cycles
- duty  output  N  last measured high time, in clk cycles
- valid  output  1  one-cycle strobe: period/duty just updated
- stalled  output  1  high while no rising edge has been seen for TIMEOUT cycles
- stall_level  output  1  synchronized pwm_in level captured when the stall was declared

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, counters are 0, synchronizer flops are 0.
- Input path:
  - 2-flop synchronizer, then a registered edge detector.
  - A rising edge is flagged 3 clk after it appears on pwm_in; falling edges are handled the same way.
  - All measurements use the synchronized signal, so the fixed latency cancels out.
- Counters:
  - cnt counts cycles since the last rising edge.
  - hcnt counts high cycles since the last rising edge.
  - Both saturate at TIMEOUT and never wrap.
- FSM state IDLE:
  - Counters are held at 0.
  - On a rising edge with en=1, go to MEAS, set cnt=1 and hcnt=1.
- FSM state MEAS:
  - cnt increments every cycle.
  - hcnt increments while the synchronized level is 1.
  - On a rising edge: latch period=cnt and duty=hcnt, pulse valid in the next cycle, restart cnt=1 and hcnt=1, clear stalled.
  - For a steady waveform (H cycles high, L cycles low), period=H+L and duty=H exactly.
- Stall handling:
  - When cnt reaches TIMEOUT in MEAS, go to IDLE, set stalled=1, set stall_level to the current synchronized level.
  - period and duty are set to 0, with no valid pulse.
  - stalled clears on the next rising edge seen in IDLE. That edge starts a new measurement; the first valid after it follows one full period later.
- First edge: the first rising edge after reset or after en rises only arms MEAS and gives no valid. The first valid occurs on the second rising edge.
- en=0 mid-measurement:
  - Go to IDLE at once and discard the partial counts.
  - period, duty and stalled hold their values.
  - No valid pulse is issued while en=0.
- Edge and timeout in the same cycle: the rising edge wins. A measurement of period=TIMEOUT is reported and stalled is not set.
- Outputs are registered. period and duty hold between valid strobes. valid is never high on two consecutive cycles.
- Minimum period measurable: 2 cycles. Shorter pulses are lost by the synchronizer, and that is acceptable.

Optional Feature:
- Macro: PWM_CAPTURE_FILT_EN.
- With the macro defined:
  - A 3-sample majority glitch filter sits after the synchronizer. The filtered level changes only when 3 consecutive synchronized samples agree.
  - Input-to-edge latency becomes 5 clk.
  - Pulses of 1–2 cycles are ignored. Both edges are delayed equally, so period/duty values are unchanged for pulses of 3 cycles or more.
- Without the macro: no filter, 3 clk latency, as described above.

Decomposition:
- Shared package pwm_pkg:
  - FSM state encoding (ST_IDLE, ST_MEAS).
  - Default counter width PWM_N=32.
  - Default PWM period constant 32'd85899 (1 kHz), shared with the generator side.
  - TIMEOUT default derived as 2×PWM period.
- One sub-module: pwm_in_sync. It holds the 2-flop synchronizer, the optional glitch filter and the edge detector. Its outputs are level, rise and fall.

Test Plan:
- Steady waveform, H=30, L=70 cycles, en=1, repeated 5 periods → no valid on the first edge; then valid once per period with period=100 and duty=30, 3 clk after each pwm_in rise.
- Duty sweep at fixed period 100, H changed 30→80 at a rising edge → the next valid reports duty=80 and period=100, with no intermediate value.
- TIMEOUT=200, pwm_in held high after a rise → 200 cycles later stalled=1, stall_level=1, period=0, duty=0, valid stays 0. The next rise clears stalled, and the first new valid follows one period later.
- Deassert en in the middle of a high phase, reassert 50 cycles later → period/duty hold their values and no valid appears; measurement restarts on the second rise after re-enable.
- Async rst asserted mid-MEAS while valid would be due → all outputs go to 0 immediately, with no valid after release until two rising edges are seen.
- With PWM_CAPTURE_FILT_EN, inject 1- and 2-cycle glitches into a 30/70 waveform → period=100 and duty=30 unchanged, latency 5 clk. Without the macro, the same stimulus produces corrupted duty/period values.
